// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-master memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/arb2_pick.sv
// Combinational two-way picker: winner 0 selects m0, 1 selects m1.
module arb2_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       rr_en,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        case (req)
            2'b10:   winner = 1'b1;
            // On a tie, round-robin favours whoever was not served last.
            2'b11:   winner = rr_en ? ~last_grant : 1'b0;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two masters onto one synchronous single-port memory.
// One access per three cycles: IDLE (arbitrate) -> ACCESS -> RESP.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_we,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state, state_n;
    logic              last_grant, last_grant_n;
    logic              win, win_n;
    logic              we_q, we_q_n;
    logic              pick;
    logic              m0_gnt_n, m1_gnt_n;
    logic              m0_rvalid_n, m1_rvalid_n;
    logic [DATA_W-1:0] m0_rdata_n, m1_rdata_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n;
    logic              mem_we_n;

    arb2_pick u_pick (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .rr_en      (RR_EN),
        .winner     (pick)
    );

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        win_n        = win;
        we_q_n       = we_q;
        m0_gnt_n     = 1'b0;
        m1_gnt_n     = 1'b0;
        m0_rvalid_n  = 1'b0;
        m1_rvalid_n  = 1'b0;
        m0_rdata_n   = m0_rdata;
        m1_rdata_n   = m1_rdata;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        mem_we_n     = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    win_n        = pick;
                    last_grant_n = pick;
                    we_q_n       = pick ? m1_we    : m0_we;
                    mem_addr_n   = pick ? m1_addr  : m0_addr;
                    mem_wdata_n  = pick ? m1_wdata : m0_wdata;
                    mem_we_n     = we_q_n;
                    m0_gnt_n     = ~pick;
                    m1_gnt_n     = pick;
                    state_n      = ACCESS;
                end
            end
            ACCESS: state_n = RESP;
            RESP: begin
                // mem_rdata reflects the address presented one cycle earlier.
                if (!we_q) begin
                    if (win) begin
                        m1_rdata_n  = mem_rdata;
                        m1_rvalid_n = 1'b1;
                    end else begin
                        m0_rdata_n  = mem_rdata;
                        m0_rvalid_n = 1'b1;
                    end
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            win        <= 1'b0;
            we_q       <= 1'b0;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            win        <= win_n;
            we_q       <= we_q_n;
            m0_gnt     <= m0_gnt_n;
            m1_gnt     <= m1_gnt_n;
            m0_rvalid  <= m0_rvalid_n;
            m1_rvalid  <= m1_rvalid_n;
            m0_rdata   <= m0_rdata_n;
            m1_rdata   <= m1_rdata_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            mem_we     <= mem_we_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a round-robin instance (a) and a
// fixed-priority instance (b), each backed by its own behavioural memory.
module tb_mem_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic       a_m0_req = 1'b0, a_m1_req = 1'b0, a_m0_we = 1'b0, a_m1_we = 1'b0;
    logic [7:0] a_m0_addr = '0, a_m1_addr = '0, a_m0_wdata = '0, a_m1_wdata = '0;
    logic       a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_we;
    logic [7:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic       b_m0_req = 1'b0, b_m1_req = 1'b0, b_m0_we = 1'b0, b_m1_we = 1'b0;
    logic [7:0] b_m0_addr = '0, b_m1_addr = '0, b_m0_wdata = '0, b_m1_wdata = '0;
    logic       b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_mem_we;
    logic [7:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] ref_a [256];
    logic [7:0] ref_b [256];
    logic [7:0] exp_rd [2];

    mem_arbiter #(.RR_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .m0_req(a_m0_req), .m1_req(a_m1_req), .m0_we(a_m0_we), .m1_we(a_m1_we),
        .m0_addr(a_m0_addr), .m1_addr(a_m1_addr), .m0_wdata(a_m0_wdata), .m1_wdata(a_m1_wdata),
        .m0_gnt(a_m0_gnt), .m1_gnt(a_m1_gnt), .m0_rvalid(a_m0_rvalid), .m1_rvalid(a_m1_rvalid),
        .m0_rdata(a_m0_rdata), .m1_rdata(a_m1_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we), .mem_rdata(a_mem_rdata)
    );

    mem_arbiter #(.RR_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .m0_req(b_m0_req), .m1_req(b_m1_req), .m0_we(b_m0_we), .m1_we(b_m1_we),
        .m0_addr(b_m0_addr), .m1_addr(b_m1_addr), .m0_wdata(b_m0_wdata), .m1_wdata(b_m1_wdata),
        .m0_gnt(b_m0_gnt), .m1_gnt(b_m1_gnt), .m0_rvalid(b_m0_rvalid), .m1_rvalid(b_m1_rvalid),
        .m0_rdata(b_m0_rdata), .m1_rdata(b_m1_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_rdata(b_mem_rdata)
    );

    // Synchronous single-port memories: read data one cycle after the address.
    always @(posedge clk) begin
        if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
        a_mem_rdata <= mem_a[a_mem_addr];
        if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
        b_mem_rdata <= mem_b[b_mem_addr];
    end

    task automatic drive_a(input bit m, input logic req, input logic we,
                           input logic [7:0] addr, input logic [7:0] wdata);
        if (m) begin
            a_m1_req = req; a_m1_we = we; a_m1_addr = addr; a_m1_wdata = wdata;
        end else begin
            a_m0_req = req; a_m0_we = we; a_m0_addr = addr; a_m0_wdata = wdata;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_m0_req = 1'b0; a_m1_req = 1'b0; b_m0_req = 1'b0; b_m1_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
    endtask

    // One request from master m on instance a, checked cycle by cycle.
    task automatic do_access(input bit m, input logic we, input logic [7:0] addr,
                             input logic [7:0] wdata, input bit scramble);
        logic [1:0] want;
        @(posedge clk); #1;
        drive_a(m, 1'b1, we, addr, wdata);
        @(negedge clk);
        vectors++;
        if ({a_m1_gnt, a_m0_gnt, a_mem_we} !== 3'b000)
            $display("FAIL idle_quiet: got gnt=%b%b we=%b want 000", a_m1_gnt, a_m0_gnt, a_mem_we);
        if ({a_m1_gnt, a_m0_gnt, a_mem_we} !== 3'b000) miscompares++;
        @(negedge clk);
        want = m ? 2'b10 : 2'b01;
        vectors++;
        if ({a_m1_gnt, a_m0_gnt} !== want) begin
            miscompares++;
            $display("FAIL gnt: got %b want %b", {a_m1_gnt, a_m0_gnt}, want);
        end
        vectors++;
        if (a_mem_we !== we || a_mem_addr !== addr || (we && a_mem_wdata !== wdata)) begin
            miscompares++;
            $display("FAIL mem_bus: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                     a_mem_we, a_mem_addr, a_mem_wdata, we, addr, wdata);
        end
        if (scramble) drive_a(m, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        else          drive_a(m, 1'b0, we, addr, wdata);
        @(negedge clk);
        vectors++;
        if ({a_m1_gnt, a_m0_gnt, a_mem_we, a_m1_rvalid, a_m0_rvalid} !== 5'b0 || a_mem_addr !== addr) begin
            miscompares++;
            $display("FAIL access_cycle: got gnt=%b%b we=%b rv=%b%b addr=%h want 0 0 0 addr=%h",
                     a_m1_gnt, a_m0_gnt, a_mem_we, a_m1_rvalid, a_m0_rvalid, a_mem_addr, addr);
        end
        if (we) ref_a[addr] = wdata;
        else    exp_rd[m]   = ref_a[addr];
        @(negedge clk);
        want = we ? 2'b00 : want;
        vectors++;
        if ({a_m1_rvalid, a_m0_rvalid} !== want) begin
            miscompares++;
            $display("FAIL rvalid: got %b want %b", {a_m1_rvalid, a_m0_rvalid}, want);
        end
        vectors++;
        if (a_m0_rdata !== exp_rd[0] || a_m1_rdata !== exp_rd[1]) begin
            miscompares++;
            $display("FAIL rdata: got %h/%h want %h/%h", a_m0_rdata, a_m1_rdata, exp_rd[0], exp_rd[1]);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        vectors++;
        if ({a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_we, a_mem_addr, a_mem_wdata,
             a_m0_rdata, a_m1_rdata} !== 37'b0) begin
            miscompares++;
            $display("FAIL reset_a: outputs not at reset values (addr=%h rd0=%h)", a_mem_addr, a_m0_rdata);
        end
        vectors++;
        if ({b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_mem_we, b_mem_addr, b_mem_wdata,
             b_m0_rdata, b_m1_rdata} !== 37'b0) begin
            miscompares++;
            $display("FAIL reset_b: outputs not at reset values (addr=%h rd0=%h)", b_mem_addr, b_m0_rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_read_basic();
        do_access(1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
        vectors++;
        if (a_m0_rdata !== 8'hA5) begin
            miscompares++;
            $display("FAIL read_10: got %h want a5", a_m0_rdata);
        end
    endtask

    task automatic test_write_then_read();
        do_access(1'b1, 1'b1, 8'h20, 8'h3C, 1'b0);
        do_access(1'b0, 1'b0, 8'h20, 8'h00, 1'b0);
        vectors++;
        if (a_m0_rdata !== 8'h3C) begin
            miscompares++;
            $display("FAIL read_back_20: got %h want 3c", a_m0_rdata);
        end
    endtask

    task automatic test_drop_in_access();
        do_access(1'b0, 1'b0, 8'($urandom), 8'h00, 1'b1);
        do_access(1'b1, 1'b0, 8'($urandom), 8'h00, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_reset_abort();
        logic [7:0] x, y;
        x = 8'($urandom);
        y = 8'($urandom);
        @(posedge clk); #1;
        drive_a(1'b0, 1'b1, 1'b0, x, 8'h00);
        @(negedge clk);
        @(negedge clk);
        drive_a(1'b0, 1'b0, 1'b0, x, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        drive_a(1'b1, 1'b1, 1'b0, y, 8'h00);
        #1;
        vectors++;
        if ({a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_we, a_mem_addr, a_mem_wdata,
             a_m0_rdata, a_m1_rdata} !== 37'b0) begin
            miscompares++;
            $display("FAIL abort_reset_vals: addr=%h rv=%b%b rd0=%h", a_mem_addr, a_m1_rvalid, a_m0_rvalid, a_m0_rdata);
        end
        @(negedge clk);
        vectors++;
        if ({a_m1_rvalid, a_m0_rvalid, a_m1_gnt, a_m0_gnt} !== 4'b0) begin
            miscompares++;
            $display("FAIL abort_no_rvalid: got rv=%b%b gnt=%b%b want 0", a_m1_rvalid, a_m0_rvalid, a_m1_gnt, a_m0_gnt);
        end
        rst_n = 1'b1;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        @(negedge clk);
        vectors++;
        if ({a_m1_gnt, a_m0_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL post_reset_gnt: got %b want 10", {a_m1_gnt, a_m0_gnt});
        end
        drive_a(1'b1, 1'b0, 1'b0, y, 8'h00);
        exp_rd[1] = ref_a[y];
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (a_m1_rvalid !== 1'b1 || a_m1_rdata !== exp_rd[1] || a_m0_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_read: got rv=%b%b data=%h want 10 data=%h",
                     a_m1_rvalid, a_m0_rvalid, a_m1_rdata, exp_rd[1]);
        end
    endtask

    // Both masters read continuously; m0 stops after cycle d0, m1 after d1.
    // Expected grants come from the tie rule plus the one-access-per-three-cycles rate.
    task automatic run_contention(input bit use_b, input int ncycles, input int d0, input int d1);
        logic [7:0] p [2];
        logic [1:0] eg, ev, og, ov;
        logic [7:0] ed, od;
        bit         last, w, r0, r1, rv_m, em;
        int         next_free, rv_cycle;
        p[0] = 8'($urandom);
        p[1] = 8'($urandom);
        last = 1'b1; next_free = 1; rv_cycle = -1; rv_m = 1'b0;
        if (use_b) begin
            b_m0_addr = p[0]; b_m1_addr = p[1]; b_m0_we = 1'b0; b_m1_we = 1'b0;
            b_m0_req = 1'b1; b_m1_req = 1'b1;
        end else begin
            a_m0_addr = p[0]; a_m1_addr = p[1]; a_m0_we = 1'b0; a_m1_we = 1'b0;
            a_m0_req = 1'b1; a_m1_req = 1'b1;
        end
        for (int c = 1; c <= ncycles; c++) begin
            @(negedge clk);
            r0 = (c <= d0);
            r1 = (c <= d1);
            ev = 2'b00; ed = 8'h00; em = rv_m;
            if (c == rv_cycle) begin
                ev[rv_m] = 1'b1;
                ed = use_b ? ref_b[p[rv_m]] : ref_a[p[rv_m]];
            end
            eg = 2'b00;
            if (c >= next_free && (r0 || r1)) begin
                w = (r0 && r1) ? (use_b ? 1'b0 : !last) : r1;
                eg[w] = 1'b1;
                last = w; next_free = c + 3; rv_cycle = c + 2; rv_m = w;
            end
            og = use_b ? {b_m1_gnt, b_m0_gnt} : {a_m1_gnt, a_m0_gnt};
            ov = use_b ? {b_m1_rvalid, b_m0_rvalid} : {a_m1_rvalid, a_m0_rvalid};
            vectors++;
            if (og !== eg) begin
                miscompares++;
                $display("FAIL contend_gnt(%s c=%0d): got %b want %b", use_b ? "fp" : "rr", c, og, eg);
            end
            vectors++;
            if (ov !== ev) begin
                miscompares++;
                $display("FAIL contend_rvalid(%s c=%0d): got %b want %b", use_b ? "fp" : "rr", c, ov, ev);
            end
            if (ev != 2'b00) begin
                if (use_b) od = em ? b_m1_rdata : b_m0_rdata;
                else       od = em ? a_m1_rdata : a_m0_rdata;
                vectors++;
                if (od !== ed) begin
                    miscompares++;
                    $display("FAIL contend_rdata(c=%0d): got %h want %h", c, od, ed);
                end
                if (!use_b) exp_rd[em] = ed;
            end
            if (c == d0) begin
                if (use_b) b_m0_req = 1'b0; else a_m0_req = 1'b0;
            end
            if (c == d1) begin
                if (use_b) b_m1_req = 1'b0; else a_m1_req = 1'b0;
            end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        run_contention(1'b0, 12, 12, 12);
    endtask

    task automatic test_fixed_priority();
        apply_reset();
        run_contention(1'b1, 15, 12, 13);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            mem_a[i] <= v; mem_b[i] <= v;
            ref_a[i] = v;  ref_b[i] = v;
        end
        mem_a[8'h10] <= 8'hA5;
        ref_a[8'h10] = 8'hA5;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        test_reset();
        test_read_basic();
        test_write_then_read();
        test_drop_in_access();
        test_random();
        test_reset_abort();
        test_round_robin();
        test_fixed_priority();
        test_read_basic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: RR_EN, default 1, 1 = round-robin between masters and 0 = fixed priority with m0 winning.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: m0_req/m1_req  in  1  access request, held until gnt.
REQ-005 SHALL have ports: m0_we/m1_we  in  1  1 = write, 0 = read; stable while req is high.
REQ-006 SHALL have ports: m0_addr/m1_addr  in  8  word address; stable while req is high.
REQ-007 SHALL have ports: m0_wdata/m1_wdata  in  8  write data; stable while req is high.
REQ-008 SHALL have ports: m0_gnt/m1_gnt  out  1  one-cycle pulse; the request has been latched.
REQ-009 SHALL have ports: m0_rvalid/m1_rvalid  out  1  one-cycle pulse; rdata is valid.
REQ-010 SHALL have ports: m0_rdata/m1_rdata  out  8  read data; holds its value until the next read for that master.
REQ-011 SHALL have port: mem_addr  out  8  address to the single-port memory.
REQ-012 SHALL have port: mem_wdata  out  8  write data to memory.
REQ-013 SHALL have port: mem_we  out  1  write strobe to memory.
REQ-014 SHALL have port: mem_rdata  in  8  synchronous read data, valid the cycle after mem_addr is presented.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS and RESP, with all outputs registered.
REQ-016 SHALL, in IDLE with no req, remain in IDLE.
REQ-017 SHALL, in IDLE with at least one req:
- pick a winner;
- latch the winner's addr, we and wdata;
- at the same edge, drive mem_addr and mem_wdata, set mem_we to the winner's we, and set that master's gnt;
- go to ACCESS.
REQ-018 SHALL, in ACCESS, clear gnt and mem_we, leave mem_addr and mem_wdata unchanged, and go to RESP.
REQ-019 SHALL, in RESP, for a read: capture mem_rdata into the winner's rdata, pulse the winner's rvalid, and return to IDLE.
REQ-020 SHALL, in RESP, for a write: pulse no rvalid and return to IDLE.
REQ-021 SHALL give a read latency of 3 cycles from the IDLE-cycle req sample to rvalid, and a throughput of one access per 3 cycles.
REQ-022 SHALL, when RR_EN=1, grant a tie to the master not granted last (last_grant register, reset value 1, so m0 wins the first tie).
REQ-023 SHALL, when RR_EN=0, grant a tie to m0; m1 starvation is accepted behaviour.
REQ-024 SHALL sample req only in IDLE; a req dropped in ACCESS or RESP has no effect on the access in flight.
REQ-025 SHALL allow a master to reassert req in the cycle after gnt; that request is arbitrated at the next IDLE.
REQ-026 SHALL never have mem_we high outside a cycle where a write gnt is high, and never pulse more than one gnt or one rvalid per cycle.
REQ-027 SHALL use no arithmetic; address and data pass through unmodified, with 8-bit widths throughout.

Reset
REQ-028 SHALL, when rst_n is low, asynchronously force: state IDLE, last_grant=1, all gnt=0, all rvalid=0, mem_we=0, mem_addr=8'h00, mem_wdata=8'h00, m0_rdata=m1_rdata=8'h00.
REQ-029 SHALL, on reset during ACCESS or RESP, abort the access with no rvalid; any write already strobed stands.
REQ-030 SHALL, on the first posedge after rst_n deasserts, be able to arbitrate.

Structure
REQ-031 SHALL place the state enum (IDLE/ACCESS/RESP) and the constants ADDR_W=8 and DATA_W=8 in a shared package mem_arb_pkg.
REQ-032 SHALL contain one sub-module, arb2_pick: combinational 2-way picker with inputs req[1:0], last_grant and rr_en, and output winner.

Verification
REQ-033 SHALL cover: m0 read addr 8'h10 with mem[8'h10]=8'hA5 -> m0_gnt pulses at cycle 1, m0_rvalid with m0_rdata=8'hA5 at cycle 3, m1 outputs quiet.
REQ-034 SHALL cover: m1 write addr 8'h20, data 8'h3C -> mem_we high for exactly one cycle with mem_addr=8'h20 and mem_wdata=8'h3C, no rvalid; a following read of 8'h20 returns 8'h3C.
REQ-035 SHALL cover: RR_EN=1, both masters requesting continuously -> grant order m0,m1,m0,m1 with gnt pulses every 3 cycles.
REQ-036 SHALL cover: RR_EN=0, both masters requesting continuously for 4 grants -> all 4 grants to m0; m1 granted only after m0_req drops.
REQ-037 SHALL cover: rst_n pulsed low during RESP of an m0 read -> no m0_rvalid, all outputs at reset values, and a new request is served normally afterwards.
REQ-038 SHALL cover: m0 drops req in ACCESS -> m0_rvalid still occurs in RESP with the correct data.
